// File: rtl/btn_reader_if.sv
// IO-bus slot for the button reader: select, word address, read strobe,
// byte write mask/data and registered read data.
interface btn_reader_if;
  logic        sel;
  logic [1:0]  addr;
  logic        rstrb;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, addr, rstrb, wmask, wdata, input rdata);
  modport slave  (input sel, addr, rstrb, wmask, wdata, output rdata);
endinterface

// File: rtl/btn_reader.sv
// Push-button reader: 2-FF synchroniser, debounce, press counter, sticky
// press/release flags and an interrupt, exposed as four IO-bus registers.
module btn_reader #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn,
  btn_reader_if.slave  bus,
  output logic         irq
);

  localparam int              DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_COUNT  = 2'd1;
  localparam logic [1:0] A_CLEAR  = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  logic             sync0_q, sync1_q;
  logic             level_q, level_d;
  logic [DB_W-1:0]  dbcnt_q, dbcnt_d;
  logic             press_pend_q, press_pend_d;
  logic             rel_pend_q, rel_pend_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_en_q, irq_en_d;
  logic [31:0]      rdata_q, rdata_d;

  logic s, db_done, rise, fall;
  logic wr, rd;
  logic clr_press, clr_rel, clr_cnt;

  logic unused_ok;
  assign unused_ok = ^{bus.wdata[31:9], bus.wdata[7:3], bus.wmask[3:2]};

  // Normalised synced input: 1 means pressed regardless of pin polarity.
  assign s       = sync1_q ^ ACTIVE_LOW;
  assign db_done = (s != level_q) && (dbcnt_q == DB_MAX);
  assign rise    = db_done &  s;
  assign fall    = db_done & ~s;

  assign wr = bus.sel & (|bus.wmask);
  assign rd = bus.sel & bus.rstrb;

  // Only byte lanes 0 and 1 carry meaningful bits.
  assign clr_press = wr && (bus.addr == A_CLEAR) && bus.wmask[0] && bus.wdata[1];
  assign clr_rel   = wr && (bus.addr == A_CLEAR) && bus.wmask[0] && bus.wdata[2];
  assign clr_cnt   = wr && (bus.addr == A_CLEAR) && bus.wmask[1] && bus.wdata[8];

  always_comb begin
    level_d = level_q;
    dbcnt_d = '0;
    if (s != level_q) begin
      if (db_done) level_d = s;
      else         dbcnt_d = dbcnt_q + 1'b1;
    end
  end

  // Set events win over a same-edge W1C, so clears are applied first.
  always_comb begin
    press_pend_d = (press_pend_q & ~clr_press) | rise;
    rel_pend_d   = (rel_pend_q & ~clr_rel) | fall;
    count_d      = clr_cnt ? '0 : count_q;
    if (rise) count_d = count_d + 1'b1;
    irq_en_d = irq_en_q;
    if (wr && (bus.addr == A_CTRL) && bus.wmask[0]) irq_en_d = bus.wdata[0];
  end

  // Read mux uses current register values, so a same-cycle write is not seen.
  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      case (bus.addr)
        A_STATUS: rdata_d = {29'd0, rel_pend_q, press_pend_q, level_q};
        A_COUNT:  rdata_d = 32'(count_q);
        A_CTRL:   rdata_d = {31'd0, irq_en_q};
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q      <= ACTIVE_LOW;
      sync1_q      <= ACTIVE_LOW;
      level_q      <= 1'b0;
      dbcnt_q      <= '0;
      press_pend_q <= 1'b0;
      rel_pend_q   <= 1'b0;
      count_q      <= '0;
      irq_en_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      sync0_q      <= btn;
      sync1_q      <= sync0_q;
      level_q      <= level_d;
      dbcnt_q      <= dbcnt_d;
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
      count_q      <= count_d;
      irq_en_q     <= irq_en_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign irq       = press_pend_q & irq_en_q;

endmodule
